// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory with req/ack handshake and programmable wait states
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] mem [DEPTH_WORDS];

  logic        commit;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_be;
  logic        c_err;
  logic [AW-1:0] c_idx;

  // With zero wait states the access commits on the accept edge, so it
  // must use the live inputs rather than the not-yet-latched copies.
  always_comb begin
    c_we    = lat_we;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    c_be    = lat_be;
    if (state == S_IDLE) begin
      c_we    = we_i;
      c_addr  = addr_i;
      c_wdata = wdata_i;
      c_be    = be_i;
    end
    c_err  = (c_addr[1:0] != 2'b00) ||
             ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));
    c_idx  = c_addr[2 +: AW];
    commit = ((state == S_IDLE) && req_i && (WAIT_CYCLES == 0)) ||
             ((state == S_WAIT) && (cnt == 4'd1));
  end

  assign busy_o = (state != S_IDLE);

  // Array is deliberately not reset; reset only blocks a pending commit.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit && c_we && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b]) begin
          mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= 32'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          ack_o   <= 1'b0;
          err_o   <= 1'b0;
          rdata_o <= 32'd0;
          if (req_i) begin
            lat_we    <= we_i;
            lat_addr  <= addr_i;
            lat_wdata <= wdata_i;
            lat_be    <= be_i;
            cnt       <= 4'(WAIT_CYCLES);
            if (commit) begin
              state   <= S_RESP;
              ack_o   <= 1'b1;
              err_o   <= c_err;
              rdata_o <= (!c_we && !c_err) ? mem[c_idx] : 32'd0;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (commit) begin
            state   <= S_RESP;
            ack_o   <= 1'b1;
            err_o   <= c_err;
            rdata_o <= (!c_we && !c_err) ? mem[c_idx] : 32'd0;
          end
        end
        S_RESP: begin
          ack_o   <= 1'b0;
          err_o   <= 1'b0;
          rdata_o <= 32'd0;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench against a word/byte reference model
module tb_data_mem_responder;

  localparam int WA = 2;
  localparam int WB = 0;
  localparam int DEPTH = 256;

  logic        clk;
  logic        rst_i;
  logic        req_a, req_b;
  logic        we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        busy_a, ack_a, err_a, busy_b, ack_b, err_b;
  logic [31:0] rdata_a, rdata_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [2][DEPTH];
  logic [3:0]  model_ok  [2][DEPTH];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_a), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .busy_o(busy_a), .ack_o(ack_a),
    .rdata_o(rdata_a), .err_o(err_a)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WB)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_b), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .busy_o(busy_b), .ack_o(ack_b),
    .rdata_o(rdata_b), .err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic o_ack(input bit sel);
    return sel ? ack_b : ack_a;
  endfunction

  function automatic logic o_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic o_err(input bit sel);
    return sel ? err_b : err_a;
  endfunction

  function automatic logic [31:0] o_rdata(input bit sel);
    return sel ? rdata_b : rdata_a;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] ok);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{ok[b]}};
    return m;
  endfunction

  // One complete access on the selected responder, checked against the model.
  task automatic do_access(input bit sel, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b);
    int lat;
    bit exp_err;
    int widx;
    logic [31:0] exp_rd, msk;
    exp_err = (a % 4 != 0) || ((a / 4) >= DEPTH);
    widx = int'(a / 4) % DEPTH;
    exp_rd = 32'd0;
    msk = 32'hFFFF_FFFF;
    if (!w && !exp_err) begin
      exp_rd = model_mem[sel][widx];
      msk = byte_mask(model_ok[sel][widx]);
    end
    @(negedge clk);
    we_i = w; addr_i = a; wdata_i = d; be_i = b;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom; be_i = 4'($urandom);
    check("busy_after_accept", 32'(o_busy(sel)), 32'd1);
    lat = 1;
    while (!o_ack(sel) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ack_latency", lat, sel ? WB + 1 : WA + 1);
    check("err", 32'(o_err(sel)), 32'(exp_err));
    check("rdata", o_rdata(sel) & msk, exp_rd & msk);
    @(negedge clk);
    check("ack_one_cycle", 32'(o_ack(sel)), 32'd0);
    check("rdata_after_ack", o_rdata(sel), 32'd0);
    check("busy_after_ack", 32'(o_busy(sel)), 32'd0);
    if (w && !exp_err) begin
      for (int k = 0; k < 4; k++) begin
        if (b[k]) begin
          model_mem[sel][widx][8*k +: 8] = d[8*k +: 8];
          model_ok[sel][widx][k] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int acks, last, low_run, guard;
    logic [31:0] a;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) begin
        model_mem[s][i] = 32'd0;
        model_ok[s][i] = 4'd0;
      end
    rst_i = 1'b0; req_a = 1'b0; req_b = 1'b0;
    we_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0; be_i = 4'd0;

    // Reset with random request activity
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_a = 1'($urandom); req_b = 1'($urandom);
      we_i = 1'($urandom); addr_i = $urandom;
      @(negedge clk);
      check("rst_ack", 32'(ack_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_err", 32'(err_a), 32'd0);
      check("rst_rdata", rdata_a, 32'd0);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;

    do_access(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    do_access(0, 0, 32'h10, 32'h0, 4'h0);
    check("model_full_word", model_mem[0][4], 32'hDEAD_BEEF);
    do_access(0, 1, 32'h10, 32'h0000_AA00, 4'b0010);
    do_access(0, 0, 32'h10, 32'h0, 4'h0);
    do_access(0, 1, 32'h0, 32'hCAFE_F00D, 4'hF);
    do_access(0, 1, 32'h14, 32'h5555_5555, 4'h0);
    do_access(0, 0, 32'h13, 32'h0, 4'h0);
    do_access(0, 1, 32'h400, 32'h1234_5678, 4'hF);
    do_access(0, 0, 32'h0, 32'h0, 4'h0);

    // Requester holding req high: accepted once per WAIT+2 cycles
    @(negedge clk);
    we_i = 1'b0; addr_i = 32'h10; req_a = 1'b1;
    acks = 0; last = 0; low_run = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!busy_a) low_run++; else low_run = 0;
      if (low_run > 1) check("hold_busy_low_run", low_run, 1);
      if (ack_a) begin
        acks++;
        check("hold_rdata", rdata_a, 32'hDEAD_AAEF);
        if (last != 0) check("hold_gap", i - last, WA + 2);
        else check("hold_first_ack", i, WA + 1);
        last = i;
      end
    end
    check("hold_ack_count", acks, 5);
    req_a = 1'b0;
    guard = 0;
    while (busy_a && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("hold_drain", 32'(busy_a), 32'd0);

    // Reset in the first wait cycle aborts the store
    do_access(0, 1, 32'h20, 32'h1111_1111, 4'hF);
    @(negedge clk);
    we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h1234_5678; be_i = 4'hF; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    check("abort_busy", 32'(busy_a), 32'd0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack_a) acks++;
    end
    check("abort_no_ack", acks, 0);
    do_access(0, 0, 32'h20, 32'h0, 4'h0);

    // Zero wait states
    do_access(1, 1, 32'h40, 32'hA5A5_0F0F, 4'hF);
    do_access(1, 0, 32'h40, 32'h0, 4'h0);
    do_access(1, 0, 32'h41, 32'h0, 4'h0);

    // Randomized traffic on both responders
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: a = {$urandom_range(0, 31), 2'b00} | 32'($urandom_range(1, 3));
        1: a = 32'($urandom_range(DEPTH, DEPTH + 64)) * 4;
        default: a = 32'($urandom_range(0, 31)) * 4;
      endcase
      do_access(1'(n % 2), 1'($urandom), a, $urandom, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
